seg_display_sequencer: RTL and testbench
========================================

// Module: seg_display_sequencer
// PURPOSE
//   Downstream display stage for the time-multiplexed NAND core. Accepts 4-bit
//   result nibbles over a valid/ready handshake and buffers them in a small FIFO.
//   Shows each nibble as a hex glyph on the 7-segment output for a fixed dwell
//   time, with a blank gap between glyphs. Drives the top-level uo_out[6:0]
//   segments, plus uo_out[7] as the busy dot.
// PARAMETERS
//   DEPTH         4    FIFO entries; power of 2, >=2
//   DWELL_CYCLES  16   cycles each glyph is shown; >=1
//   GAP_CYCLES    2    blank cycles after each glyph; >=0 (0 = no gap state)
// PORTS
//   clk        in   1  clock; all state on rising edge
//   rst_n      in   1  reset, asynchronous, active-low
//   ena        in   1  design enable; low freezes block
//   in_valid   in   1  producer has a nibble
//   in_data    in   4  nibble to display
//   in_ready   out  1  = ena & !full (combinational)
//   segments   out  7  registered, active-high, bit0=a .. bit6=g
//   dp         out  1  registered busy dot: 1 in SHOW/GAP, 0 in IDLE
// BEHAVIOUR
//   Reset (async assert, sync to clk release): FIFO empty, state IDLE,
//     segments=7'h40 (dash), dp=0, counter=0.
//   Push: on an edge where in_valid & in_ready, in_data written at tail.
//     When full, in_ready=0 even if a pop occurs that cycle. No bypass.
//   Pop: only on the SHOW-entry edge. Push and pop on the same edge leave
//     count unchanged. Count range is 0..DEPTH.
//   FSM (advances only when ena=1):
//     IDLE: if FIFO non-empty -> SHOW. Pop head; segments<=hex(head); dp<=1;
//       cnt<=DWELL_CYCLES-1.
//     SHOW: cnt!=0 -> cnt--. cnt==0: GAP_CYCLES>0 -> GAP (segments<=0,
//       cnt<=GAP_CYCLES-1). Else: go to next-glyph decision.
//     GAP: cnt!=0 -> cnt--. cnt==0: go to next-glyph decision.
//     next-glyph: FIFO non-empty -> SHOW (pop, as above). Else -> IDLE
//       (segments<=7'h40, dp<=0).
//   Timing: nibble pushed at edge E0 in IDLE is shown from edge E1 for
//     exactly DWELL_CYCLES cycles. It is then blank for exactly GAP_CYCLES.
//     Back-to-back glyphs have no extra idle cycle.
//   hex(): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C
//     C:39 d:5E E:79 F:71.
//   ena=0: no push (in_ready=0), no pop. FSM, counter, FIFO and outputs
//     hold. Resume exactly where frozen.
//   Reset mid-operation: FIFO contents discarded; outputs to reset values at once.
//   Pointers wrap modulo DEPTH. Full/empty come from a (log2(DEPTH)+1)-bit count.
// TESTING (bench params DEPTH=4, DWELL_CYCLES=4, GAP_CYCLES=1, ena=1 unless noted)
//   1 Reset: rst_n=0 -> segments=40, dp=0, in_ready=1. Release; idle 10 cycles
//     -> unchanged.
//   2 Single push 3 -> 1 cycle later segments=4F for 4 cycles, then 00 for
//     1 cycle, then 40. dp=1 during the 5 SHOW/GAP cycles, then 0.
//   3 Push A,B,C,D,E,F on consecutive cycles with in_valid held -> first 5
//     accepted; in_ready=0 until next pop. F is accepted then. Display shows
//     77,7C,39,5E,79,71, each 4 cycles, separated by 1-cycle 00.
//   4 Rebuild with GAP_CYCLES=0; push 1,2 -> 06 x4 cycles, then 5B x4, then 40.
//     No blank cycle between glyphs.
//   5 During SHOW of 8, drop ena 6 cycles -> segments=7F, dp=1, in_ready=0
//     frozen. Raise ena -> remaining dwell cycles complete; total 7F time=4.
//   6 During SHOW with 3 entries queued, pulse rst_n low mid-cycle -> segments=40,
//     dp=0 immediately. After release, in_ready=1 and no queued glyph appears.

Source files
------------

// File: rtl/seg_display_sequencer.sv
// seg_display_sequencer: buffers 4-bit nibbles from a valid/ready producer in a
// small FIFO and shows each one as a hex glyph on a 7-segment display for a
// fixed dwell time, followed by an optional blank gap. The dp output is a busy
// indicator that is lit while a glyph or its trailing gap is on the display.
module seg_display_sequencer #(
    parameter int DEPTH        = 4,
    parameter int DWELL_CYCLES = 16,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic [6:0] segments,
    output logic       dp
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNTW-1:0] DWELL_LOAD = CNTW'(DWELL_CYCLES - 1);
    localparam logic [CNTW-1:0] GAP_LOAD   = CNTW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [6:0]      SEG_DASH   = 7'h40;
    localparam logic [6:0]      SEG_BLANK  = 7'h00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_GAP
    } state_t;

    state_t            state, state_next;
    logic [CNTW-1:0]   cnt, cnt_next;
    logic [6:0]        seg_next;
    logic              dp_next;

    logic [3:0]        mem [DEPTH];
    logic [AW-1:0]     head, tail;
    logic [CW-1:0]     count;
    logic              full, empty, push, pop;

    // Hex digit to active-high segment pattern (bit0 = a .. bit6 = g).
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Full is judged on the pre-edge count, so a same-cycle pop never opens a full FIFO.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = ena & ~full;
    assign push     = in_valid & in_ready;

    // FIFO storage: written at the tail on every accepted nibble.
    // NOTE: storage is deliberately left out of reset; only pointers and count need a known value.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision; everything holds while ena is low.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        if (ena) begin
            case (state)
                S_IDLE: begin
                    if (!empty) state_next = S_SHOW;
                end
                S_SHOW: begin
                    if (cnt == '0) begin
                        if (GAP_CYCLES > 0)  state_next = S_GAP;
                        else if (empty)      state_next = S_IDLE;
                        else                 state_next = S_SHOW;
                    end
                end
                S_GAP: begin
                    if (cnt == '0) state_next = empty ? S_IDLE : S_SHOW;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Datapath actions per state: pop on SHOW entry, load counter, pick next display values.
    always_comb begin
        pop      = 1'b0;
        cnt_next = cnt;
        seg_next = segments;
        dp_next  = dp;
        if (ena) begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        pop      = 1'b1;
                        seg_next = hex7(mem[head]);
                        dp_next  = 1'b1;
                        cnt_next = DWELL_LOAD;
                    end
                end
                S_SHOW, S_GAP: begin
                    if (cnt != '0) begin
                        cnt_next = cnt - CNTW'(1);
                    end else if (state == S_SHOW && GAP_CYCLES > 0) begin
                        seg_next = SEG_BLANK;
                        cnt_next = GAP_LOAD;
                    end else if (!empty) begin
                        pop      = 1'b1;
                        seg_next = hex7(mem[head]);
                        dp_next  = 1'b1;
                        cnt_next = DWELL_LOAD;
                    end else begin
                        seg_next = SEG_DASH;
                        dp_next  = 1'b0;
                        cnt_next = '0;
                    end
                end
                default: begin
                    seg_next = SEG_DASH;
                    dp_next  = 1'b0;
                    cnt_next = '0;
                end
            endcase
        end
    end

    // Registered display outputs and dwell/gap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segments <= SEG_DASH;
            dp       <= 1'b0;
            cnt      <= '0;
        end else begin
            segments <= seg_next;
            dp       <= dp_next;
            cnt      <= cnt_next;
        end
    end

endmodule

// File: tb/tb_seg_display_sequencer.sv
// Bench for seg_display_sequencer: two instances (gap of 1 and of 0 cycles) share
// one stimulus stream. A timeline-based reference model pushes each edge's
// expected display into a scoreboard that a separate monitor drains.
module tb_seg_display_sequencer;

    localparam int DEPTH = 4;
    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       rdy0, rdy1, dp0, dp1;
    logic [6:0] seg0, seg1;

    seg_display_sequencer #(.DEPTH(DEPTH), .DWELL_CYCLES(DWELL), .GAP_CYCLES(1)) u_dut_gap (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .segments(seg0), .dp(dp0)
    );

    seg_display_sequencer #(.DEPTH(DEPTH), .DWELL_CYCLES(DWELL), .GAP_CYCLES(0)) u_dut_nogap (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .segments(seg1), .dp(dp1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg0;
        logic       dp0;
        logic [6:0] seg1;
        logic       dp1;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;

    // Reference model: a queue of pending nibbles plus, per instance, the glyph
    // on display and how many frames of its dwell+gap window are still to come.
    logic [3:0] mq [2][$];
    bit         busy [2];
    int         remaining [2];
    logic [3:0] glyph [2];

    function automatic int gap_cfg(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic logic [6:0] hex_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int k);
        int pos;
        if (!busy[k]) return 7'h40;
        pos = DWELL + gap_cfg(k) - 1 - remaining[k];
        return (pos < DWELL) ? hex_ref(glyph[k]) : 7'h00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            busy[k]      = 1'b0;
            remaining[k] = 0;
            glyph[k]     = 4'h0;
        end
    endtask

    // One clock edge of the reference model: the display advances using the
    // pre-edge queue, then an accepted nibble joins the tail.
    task automatic model_edge(input int k, input bit v, input logic [3:0] d, input bit e);
        bit rdy;
        if (!e) return;
        rdy = (mq[k].size() < DEPTH);
        if (busy[k] && remaining[k] > 0) begin
            remaining[k]--;
        end else if (mq[k].size() > 0) begin
            glyph[k]     = mq[k].pop_front();
            busy[k]      = 1'b1;
            remaining[k] = DWELL + gap_cfg(k) - 1;
        end else begin
            busy[k] = 1'b0;
        end
        if (v && rdy) mq[k].push_back(d);
    endtask

    // Drive one cycle of stimulus, check in_ready, and queue the expected display.
    task automatic step(input bit v, input logic [3:0] d, input bit e, output bit acc0);
        exp_t x;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        ena      = e;
        #1;
        check("in_ready_gap1", {31'b0, rdy0}, {31'b0, e && (mq[0].size() < DEPTH)});
        check("in_ready_gap0", {31'b0, rdy1}, {31'b0, e && (mq[1].size() < DEPTH)});
        acc0 = v && e && (mq[0].size() < DEPTH);
        model_edge(0, v, d, e);
        model_edge(1, v, d, e);
        x.seg0 = exp_seg(0);
        x.dp0  = busy[0];
        x.seg1 = exp_seg(1);
        x.dp1  = busy[1];
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        bit unused_acc;
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b1, unused_acc);
    endtask

    // Assert reset mid-cycle, check outputs go to reset values at once, then release.
    task automatic do_reset();
        @(negedge clk);
        #2;
        in_valid = 1'b0;
        ena      = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("rst_seg_gap1", {25'b0, seg0}, 32'h40);
        check("rst_dp_gap1",  {31'b0, dp0},  32'h0);
        check("rst_seg_gap0", {25'b0, seg1}, 32'h40);
        check("rst_dp_gap0",  {31'b0, dp1},  32'h0);
        check("rst_in_ready", {31'b0, rdy0}, 32'h1);
        model_clear();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Monitor: after each rising edge compare the registered display against the scoreboard.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("segments_gap1", {25'b0, seg0}, {25'b0, x.seg0});
                check("dp_gap1",       {31'b0, dp0},  {31'b0, x.dp0});
                check("segments_gap0", {25'b0, seg1}, {25'b0, x.seg1});
                check("dp_gap0",       {31'b0, dp1},  {31'b0, x.dp1});
            end
        end
    end

    initial begin
        bit acc;
        int guard;
        model_clear();

        // Reset from power-up, then idle: display must stay a dash.
        #2 rst_n = 1'b0;
        #2;
        check("por_seg", {25'b0, seg0}, 32'h40);
        check("por_dp",  {31'b0, dp0},  32'h0);
        check("por_rdy", {31'b0, rdy0}, 32'h1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(10);

        // Single glyph.
        step(1'b1, 4'h3, 1'b1, acc);
        idle(8);

        // A..F with valid held until each is taken; the FIFO fills and back-pressures.
        for (int n = 10; n < 16; n++) begin
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 50) begin
                step(1'b1, 4'(n), 1'b1, acc);
                guard++;
            end
            if (!acc) check("accept_timeout", 32'(guard), 32'd0);
        end
        idle(40);

        // Two glyphs back to back (no blank between them on the gap-0 instance).
        step(1'b1, 4'h1, 1'b1, acc);
        step(1'b1, 4'h2, 1'b1, acc);
        idle(15);

        // Freeze in the middle of a dwell, then resume.
        step(1'b1, 4'h8, 1'b1, acc);
        idle(2);
        for (int i = 0; i < 6; i++) step(1'b1, 4'h9, 1'b0, acc);
        idle(10);

        // Reset while glyphs are queued; nothing queued may reappear.
        for (int n = 5; n < 10; n++) step(1'b1, 4'(n), 1'b1, acc);
        idle(2);
        do_reset();
        idle(8);

        // Random traffic with occasional freezes and resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 9) != 0), acc);
            end
        end
        idle(30);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
